// File: rtl/rom_loader_pkg.sv
// Shared ROM types: word and address widths, default depth and the loader state encoding.
package rom_loader_pkg;

    localparam int ROM_DEPTH_DEFAULT = 256;
    localparam int ADDR_W            = $clog2(ROM_DEPTH_DEFAULT);

    typedef logic [31:0]       word_t;
    typedef logic [ADDR_W-1:0] rom_address_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/rom_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler: each accepted byte lands in the lane given by a 2-bit counter.
import rom_loader_pkg::*;

module byte_word_assembler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] byte_in,
    output word_t      word,
    output logic [1:0] lane,
    output logic       full
);

    // clear wins over shift so a session boundary always restarts at lane 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            lane <= 2'd0;
        end else if (clear) begin
            word <= '0;
            lane <= 2'd0;
        end else if (shift_en) begin
            word[{lane, 3'b000} +: 8] <= byte_in;
            lane                      <= lane + 2'd1;
        end
    end

    assign full = (lane == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, one word per write strobe.
import rom_loader_pkg::*;

module rom_loader #(
    parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         mem_write_enable,
    output logic [$clog2(ROM_DEPTH)-1:0] mem_address,
    output word_t                        mem_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [15:0]                  word_count
);

    loader_state_t state, next_state;

    logic [$clog2(ROM_DEPTH)-1:0] addr;
    logic [15:0] n_words;
    logic [15:0] header_n;
    word_t       asm_word;
    logic [1:0]  lane;
    logic        full;
    logic        fire;
    logic        start_accept;
    logic        header_done;
    logic        header_over;

    assign fire         = byte_valid && byte_ready;
    assign start_accept = start && (state == ST_IDLE || state == ST_DONE);
    assign header_n     = {byte_data, asm_word[7:0]};
    assign header_done  = (state == ST_HEADER) && fire && (lane == 2'd1);
    assign header_over  = 32'(header_n) > 32'(ROM_DEPTH);

    // Header bytes reuse the assembler lanes; it is cleared again before the first data byte
    byte_word_assembler u_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_accept || header_done),
        .shift_en (fire),
        .byte_in  (byte_data),
        .word     (asm_word),
        .lane     (lane),
        .full     (full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state       = state;
        byte_ready       = 1'b0;
        mem_write_enable = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_HEADER;
            end
            ST_HEADER: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (header_done) begin
                    if (header_n == 16'd0 || header_over) next_state = ST_DONE;
                    else                                  next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (fire && full) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                busy             = 1'b1;
                mem_write_enable = 1'b1;
                if (word_count + 16'd1 == n_words) next_state = ST_DONE;
                else                               next_state = ST_DATA;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) next_state = ST_HEADER;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // After a full image the address counter rolls to 0 in DONE; it is only observed during WRITE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            n_words    <= 16'd0;
            word_count <= 16'd0;
            error      <= 1'b0;
        end else begin
            if (start_accept) begin
                addr       <= '0;
                word_count <= 16'd0;
                error      <= 1'b0;
            end
            if (header_done) begin
                n_words <= header_n;
                if (header_over) error <= 1'b1;
            end
            if (state == ST_WRITE) begin
                addr       <= addr + 1'b1;
                word_count <= word_count + 16'd1;
            end
        end
    end

    assign mem_address = addr;
    assign mem_data    = asm_word;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed streams push expected writes, a monitor checks every strobe.
module tb_rom_loader;

    localparam int DEPTH = 256;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    wr_t         expected_q[$];
    logic [31:0] image [DEPTH];
    int          checks_total  = 0;
    int          checks_passed = 0;

    rom_loader #(.ROM_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .word_count       (word_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Write strobes are sampled mid-cycle and matched against the oldest expected write
    always @(negedge clk) begin
        if (!reset && mem_write_enable) begin
            image[mem_address] = mem_data;
            if (expected_q.size() == 0) begin
                check_output("unexpected_write_addr", {24'd0, mem_address}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = expected_q.pop_front();
                check_output("write_addr", {24'd0, mem_address}, {24'd0, w.addr});
                check_output("write_data", mem_data, w.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit accepted;
        accepted   = 1'b0;
        byte_data  = b;
        byte_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (byte_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk); #1;
        end else begin
            check_output("byte_accept_timeout", 32'd0, 32'd1);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
    endtask

    task automatic push_write(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        expected_q.push_back(w);
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check_output(name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check_output({tag, "_mem_we"},     {31'd0, mem_write_enable}, 32'd0);
        check_output({tag, "_mem_addr"},   {24'd0, mem_address}, 32'd0);
        check_output({tag, "_mem_data"},   mem_data, 32'd0);
        check_output({tag, "_busy"},       {31'd0, busy}, 32'd0);
        check_output({tag, "_done"},       {31'd0, done}, 32'd0);
        check_output({tag, "_error"},      {31'd0, error}, 32'd0);
        check_output({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Two-word program
        $display("[TB] two-word stream");
        pulse_start();
        push_write(8'd0, 32'h0000_0013);
        push_write(8'd1, 32'h0010_0093);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_done("two_word_done");
        check_output("two_word_count", {16'd0, word_count}, 32'd2);
        check_output("two_word_error", {31'd0, error}, 32'd0);

        // Empty image: done right after the second header byte
        $display("[TB] zero-length header");
        pulse_start();
        send_byte(8'h00);
        check_output("zero_len_done_early", {31'd0, done}, 32'd0);
        check_output("zero_len_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00);
        check_output("zero_len_done", {31'd0, done}, 32'd1);
        check_output("zero_len_count", {16'd0, word_count}, 32'd0);

        // Oversized header (257) is rejected without writes
        $display("[TB] oversized header");
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        check_output("oversize_error", {31'd0, error}, 32'd1);
        check_output("oversize_done", {31'd0, done}, 32'd1);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_output("oversize_not_ready", {31'd0, byte_ready}, 32'd0);
        end
        byte_valid = 1'b0;
        check_output("oversize_count", {16'd0, word_count}, 32'd0);

        // One word with idle gaps; a start pulse mid-word must be ignored
        $display("[TB] stalled single word");
        pulse_start();
        check_output("gap_error_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        push_write(8'd0, 32'hDEAD_BEEF);
        send_byte(8'hEF);
        pulse_start();
        repeat (2) @(posedge clk); #1;
        send_byte(8'hBE);
        repeat (3) @(posedge clk); #1;
        send_byte(8'hAD);
        repeat (3) @(posedge clk); #1;
        send_byte(8'hDE);
        check_output("gap_write_latency", {31'd0, mem_write_enable}, 32'd1);
        wait_done("gap_done");
        check_output("gap_count", {16'd0, word_count}, 32'd1);

        // Reset part-way through a word abandons it
        $display("[TB] reset mid-word");
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        check_output("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        push_write(8'd0, 32'h4433_2211);
        send_word(32'h4433_2211);
        wait_done("after_reset_done");

        // Full image of incrementing words
        $display("[TB] full image");
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            push_write(8'(i), 32'(i) * 32'h0001_0001 + 32'h0100_0000);
            send_word(32'(i) * 32'h0001_0001 + 32'h0100_0000);
        end
        wait_done("full_done");
        check_output("full_count", {16'd0, word_count}, 32'd256);
        check_output("full_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (image[i] !== 32'(i) * 32'h0001_0001 + 32'h0100_0000)
                check_output("readback", image[i], 32'(i) * 32'h0001_0001 + 32'h0100_0000);
        end
        check_output("readback_last", image[DEPTH-1], 32'h0100_0000 + 32'd255 * 32'h0001_0001);

        repeat (2) @(posedge clk);
        check_output("scoreboard_empty", expected_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ROM_DEPTH, default 256, number of 32-bit words in the instruction ROM image; SHALL be a power of two.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  one-cycle pulse opening a load session; ignored unless state is IDLE or DONE.
REQ-005 Port byte_valid  input  1  byte_data carries a valid stream byte.
REQ-006 Port byte_data  input  8  stream byte.
REQ-007 Port byte_ready  output  1  loader accepts byte this cycle; transfer occurs when byte_valid and byte_ready are both high.
REQ-008 Port mem_write_enable  output  1  one-cycle write strobe to instruction memory.
REQ-009 Port mem_address  output  RomAddress  word index being written.
REQ-010 Port mem_data  output  Word  assembled instruction word.
REQ-011 Port busy  output  1  high in HEADER, DATA and WRITE states.
REQ-012 Port done  output  1  high while in DONE state.
REQ-013 Port error  output  1  header word count exceeded ROM_DEPTH; sticky until next start or reset.
REQ-014 Port word_count  output  16  number of words written in the current/last session.

Function
REQ-015 Stream format SHALL be: 2-byte little-endian header N (word count), then N words, each 4 bytes little-endian (first byte -> bits 7:0).
REQ-016 States SHALL be IDLE, HEADER, DATA, WRITE, DONE.
REQ-017 IDLE/DONE + start -> HEADER next cycle; word_count, error, byte counter, address counter cleared on that edge.
REQ-018 HEADER: byte_ready high; after 2nd accepted byte, N latched; N == 0 -> DONE; N > ROM_DEPTH -> error set, DONE, no writes; else -> DATA.
REQ-019 DATA: byte_ready high; bytes shifted into word assembly register at lane = byte counter (0..3); after 4th accepted byte -> WRITE.
REQ-020 WRITE: byte_ready low; mem_write_enable high for exactly one cycle with mem_address = current address counter, mem_data = assembled word; latency from 4th byte acceptance to strobe is exactly 1 cycle.
REQ-021 On leaving WRITE, address counter and word_count increment; word_count == N -> DONE, else -> DATA.
REQ-022 Address counter SHALL never wrap within a session (guaranteed by REQ-018); N == ROM_DEPTH writes addresses 0..ROM_DEPTH-1.
REQ-023 byte_ready SHALL be low in IDLE, WRITE, DONE; bytes presented there are not consumed.
REQ-024 start during HEADER/DATA/WRITE SHALL be ignored.
REQ-025 byte_valid deasserted mid-word SHALL stall without losing partial bytes; no timeout.
REQ-026 mem_write_enable SHALL be low in every state except WRITE.

Reset
REQ-027 Reset asserted SHALL immediately force: state IDLE, byte_ready 0, mem_write_enable 0, mem_address 0, mem_data 0, busy 0, done 0, error 0, word_count 0, internal counters 0.
REQ-028 Reset mid-session SHALL abandon the session; a partially assembled word is never written.

Structure
REQ-029 Word, RomAddress and ROM_DEPTH default SHALL come from the shared ROM package used by rom and the decoder.
REQ-030 Loader state enum SHALL be declared in the same package for bench visibility.
REQ-031 Byte-to-word assembly SHALL be a sub-module byte_word_assembler (shift register + 2-bit lane counter, full flag).

Verification
REQ-032 start, stream 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0, 0x00100093 @1; done=1, word_count=2, error=0.
REQ-033 start, header 00 00 -> DONE 3 cycles after start pulse, no write strobe, word_count=0.
REQ-034 ROM_DEPTH=256, header 01 01 (257) -> error=1, done=1, no writes, further bytes not accepted.
REQ-035 N=1, byte_valid gaps of 3 idle cycles between each byte -> single write 1 cycle after 4th byte, correct word.
REQ-036 reset asserted after 2 of 4 data bytes -> all outputs zero same cycle, no write; new session afterwards writes address 0.
REQ-037 N=ROM_DEPTH full image of incrementing words -> last write at address ROM_DEPTH-1, word_count=ROM_DEPTH, decoder readback via rom matches.
